// File: rtl/load_store_unit_if.sv
// -----------------------------------------------------------------------------
// load_store_unit_if
// Request/response bundle between the core's execute stage and the
// load_store_unit.
//   master : core side. Drives req_*, receives req_ready and resp_*.
//   slave  : load_store_unit side.
// Signals:
//   req_valid/req_ready  accept handshake (transfer when both high at clk edge)
//   req_write            1 = store, 0 = load
//   req_size             00 byte, 01 halfword, 10 word, 11 reserved
//   req_signed           loads only: sign-extend byte/halfword
//   req_addr, req_wdata  byte address, right-aligned store data
//   resp_valid           one-cycle completion pulse, no backpressure
//   resp_fault           qualifies resp_valid: rejected, no memory access made
//   resp_rdata           extended load data, 0 for stores and faults
// -----------------------------------------------------------------------------
interface load_store_unit_if #(
  parameter int ADDR_W = 32
);
  logic              req_valid;
  logic              req_ready;
  logic              req_write;
  logic [1:0]        req_size;
  logic              req_signed;
  logic [ADDR_W-1:0] req_addr;
  logic [31:0]       req_wdata;
  logic              resp_valid;
  logic              resp_fault;
  logic [31:0]       resp_rdata;

  modport master (
    output req_valid, req_write, req_size, req_signed, req_addr, req_wdata,
    input  req_ready, resp_valid, resp_fault, resp_rdata
  );

  modport slave (
    input  req_valid, req_write, req_size, req_signed, req_addr, req_wdata,
    output req_ready, resp_valid, resp_fault, resp_rdata
  );
endinterface

// File: rtl/load_store_unit.sv
// -----------------------------------------------------------------------------
// load_store_unit
// Turns one core load/store request into data_memory control cycles: checks
// size and alignment, splits halfword stores into two byte writes, and
// extracts and extends load data, answering each request with exactly one
// resp_valid pulse.
//
// Ports:
//   clk, rst_n            clock (rising edge), synchronous active-low reset
//   bus (slave)           request/response bundle, see load_store_unit_if
//   o_mem_address         data_memory address (registered)
//   o_mem_write_data      data_memory write_data (registered)
//   o_mem_write_enable    data_memory write_enable, one-cycle strobe
//   o_mem_read_enable     data_memory read_enable, one-cycle strobe
//   o_mem_byte_enable     data_memory byte_enable (registered)
//   i_mem_read_data       data_memory read_data, valid the cycle after a read
//                         strobe, 0 otherwise
//
// Optional feature: define LSU_RANGE_CHECK_EN to also fault any access whose
// last byte lies beyond MEM_BYTES-1. Without it the full address is passed
// through and data_memory aliases it.
// -----------------------------------------------------------------------------
module load_store_unit #(
  parameter int ADDR_W    = 32,
  parameter int MEM_BYTES = 4096
) (
  input  logic               clk,
  input  logic               rst_n,
  load_store_unit_if.slave   bus,
  output logic [ADDR_W-1:0]  o_mem_address,
  output logic [31:0]        o_mem_write_data,
  output logic               o_mem_write_enable,
  output logic               o_mem_read_enable,
  output logic               o_mem_byte_enable,
  input  logic [31:0]        i_mem_read_data
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ST_HI   = 2'd1,
    LD_WAIT = 2'd2
  } state_t;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;

  // Registered state and outputs
  state_t            r_state;
  logic              r_resp_pend;   // store strobe out now, respond next cycle
  logic              r_ld_sample;   // second LD_WAIT cycle: read data present
  logic [1:0]        r_size;
  logic              r_signed;
  logic [7:0]        r_hi_byte;     // upper byte of a split halfword store
  logic [ADDR_W-1:0] r_mem_address;
  logic [31:0]       r_mem_write_data;
  logic              r_mem_write_enable;
  logic              r_mem_read_enable;
  logic              r_mem_byte_enable;
  logic              r_resp_valid;
  logic              r_resp_fault;
  logic [31:0]       r_resp_rdata;

  // Next-state values
  state_t            w_state;
  logic              w_resp_pend;
  logic              w_ld_sample;
  logic [1:0]        w_size;
  logic              w_signed;
  logic [7:0]        w_hi_byte;
  logic [ADDR_W-1:0] w_mem_address;
  logic [31:0]       w_mem_write_data;
  logic              w_mem_write_enable;
  logic              w_mem_read_enable;
  logic              w_mem_byte_enable;
  logic              w_resp_valid;
  logic              w_resp_fault;
  logic [31:0]       w_resp_rdata;

  logic              w_ready;
  logic              w_align_fault;
  logic              w_range_fault;
  logic              w_fault;

  // A store strobe in flight keeps us in IDLE but must not overlap a new
  // request's response, so acceptance also waits for it to retire.
  assign w_ready = (r_state == IDLE) && !r_resp_pend;

  always_comb begin
    unique case (bus.req_size)
      SZ_HALF: w_align_fault = bus.req_addr[0];
      SZ_WORD: w_align_fault = (bus.req_addr[1:0] != 2'b00);
      SZ_BYTE: w_align_fault = 1'b0;
      default: w_align_fault = 1'b1;   // reserved size
    endcase
  end

`ifdef LSU_RANGE_CHECK_EN
  localparam logic [ADDR_W:0] LAST_BYTE = (ADDR_W+1)'(MEM_BYTES - 1);
  logic [ADDR_W:0] w_last_byte;

  // One extra bit so addr+3 near the top of the address space cannot wrap
  // back into range.
  always_comb begin
    unique case (bus.req_size)
      SZ_HALF: w_last_byte = {1'b0, bus.req_addr} + (ADDR_W+1)'(1);
      SZ_WORD: w_last_byte = {1'b0, bus.req_addr} + (ADDR_W+1)'(3);
      default: w_last_byte = {1'b0, bus.req_addr};
    endcase
  end

  assign w_range_fault = (w_last_byte > LAST_BYTE);
`else
  logic w_unused_mem_bytes;

  // MEM_BYTES only matters to the range check; tie it off here.
  assign w_unused_mem_bytes = (MEM_BYTES != 0);
  assign w_range_fault      = 1'b0;
`endif

  assign w_fault = w_align_fault | w_range_fault;

  // NOTE: every signal written here gets a default first, so no path through
  // the case statement can leave one unassigned and infer a latch.
  always_comb begin
    w_state            = r_state;
    w_resp_pend        = 1'b0;
    w_ld_sample        = 1'b0;
    w_size             = r_size;
    w_signed           = r_signed;
    w_hi_byte          = r_hi_byte;
    w_mem_address      = r_mem_address;
    w_mem_write_data   = r_mem_write_data;
    w_mem_byte_enable  = r_mem_byte_enable;
    w_mem_write_enable = 1'b0;
    w_mem_read_enable  = 1'b0;
    w_resp_valid       = 1'b0;
    w_resp_fault       = 1'b0;
    w_resp_rdata       = '0;

    unique case (r_state)
      IDLE: begin
        if (r_resp_pend) begin
          w_resp_valid = 1'b1;
        end else if (bus.req_valid) begin
          if (w_fault) begin
            w_resp_valid = 1'b1;
            w_resp_fault = 1'b1;
          end else if (bus.req_write) begin
            w_mem_write_enable = 1'b1;
            w_mem_address      = bus.req_addr;
            unique case (bus.req_size)
              SZ_WORD: begin
                w_mem_byte_enable = 1'b0;
                w_mem_write_data  = bus.req_wdata;
                w_resp_pend       = 1'b1;
              end
              SZ_HALF: begin
                w_mem_byte_enable = 1'b1;
                w_mem_write_data  = {24'b0, bus.req_wdata[7:0]};
                w_hi_byte         = bus.req_wdata[15:8];
                w_state           = ST_HI;
              end
              default: begin
                w_mem_byte_enable = 1'b1;
                w_mem_write_data  = {24'b0, bus.req_wdata[7:0]};
                w_resp_pend       = 1'b1;
              end
            endcase
          end else begin
            w_mem_read_enable = 1'b1;
            w_mem_address     = bus.req_addr;
            w_mem_byte_enable = (bus.req_size == SZ_BYTE);
            w_size            = bus.req_size;
            w_signed          = bus.req_signed;
            w_state           = LD_WAIT;
          end
        end
      end

      ST_HI: begin
        w_mem_write_enable = 1'b1;
        w_mem_byte_enable  = 1'b1;
        w_mem_address      = r_mem_address + ADDR_W'(1);
        w_mem_write_data   = {24'b0, r_hi_byte};
        w_resp_pend        = 1'b1;
        w_state            = IDLE;
      end

      LD_WAIT: begin
        if (!r_ld_sample) begin
          // Read strobe is out this cycle; data_memory answers next cycle.
          w_ld_sample = 1'b1;
        end else begin
          w_resp_valid = 1'b1;
          w_state      = IDLE;
          unique case (r_size)
            SZ_BYTE: w_resp_rdata = {{24{r_signed & i_mem_read_data[7]}},
                                     i_mem_read_data[7:0]};
            SZ_HALF: w_resp_rdata = {{16{r_signed & i_mem_read_data[15]}},
                                     i_mem_read_data[15:0]};
            default: w_resp_rdata = i_mem_read_data;
          endcase
        end
      end

      default: w_state = IDLE;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state            <= IDLE;
      r_resp_pend        <= 1'b0;
      r_ld_sample        <= 1'b0;
      r_size             <= '0;
      r_signed           <= 1'b0;
      r_hi_byte          <= '0;
      r_mem_address      <= '0;
      r_mem_write_data   <= '0;
      r_mem_write_enable <= 1'b0;
      r_mem_read_enable  <= 1'b0;
      r_mem_byte_enable  <= 1'b0;
      r_resp_valid       <= 1'b0;
      r_resp_fault       <= 1'b0;
      r_resp_rdata       <= '0;
    end else begin
      r_state            <= w_state;
      r_resp_pend        <= w_resp_pend;
      r_ld_sample        <= w_ld_sample;
      r_size             <= w_size;
      r_signed           <= w_signed;
      r_hi_byte          <= w_hi_byte;
      r_mem_address      <= w_mem_address;
      r_mem_write_data   <= w_mem_write_data;
      r_mem_write_enable <= w_mem_write_enable;
      r_mem_read_enable  <= w_mem_read_enable;
      r_mem_byte_enable  <= w_mem_byte_enable;
      r_resp_valid       <= w_resp_valid;
      r_resp_fault       <= w_resp_fault;
      r_resp_rdata       <= w_resp_rdata;
    end
  end

  assign bus.req_ready      = w_ready;
  assign bus.resp_valid     = r_resp_valid;
  assign bus.resp_fault     = r_resp_fault;
  assign bus.resp_rdata     = r_resp_rdata;
  assign o_mem_address      = r_mem_address;
  assign o_mem_write_data   = r_mem_write_data;
  assign o_mem_write_enable = r_mem_write_enable;
  assign o_mem_read_enable  = r_mem_read_enable;
  assign o_mem_byte_enable  = r_mem_byte_enable;

endmodule

// File: tb/tb_load_store_unit.sv
// -----------------------------------------------------------------------------
// tb_load_store_unit
// Drives load_store_unit with directed and random requests. A request-level
// reference model (byte-array memory, expected responses and memory strobes
// keyed by cycle number) is compared against the DUT every cycle; a small
// behavioural data_memory answers the DUT's strobes. Directed cases also
// check literal values.
// -----------------------------------------------------------------------------
module tb_load_store_unit;

  localparam int ADDR_W    = 32;
  localparam int MEM_BYTES = 4096;

  typedef struct {
    int          cyc;
    logic        fault;
    logic [31:0] rdata;
  } resp_t;

  typedef struct {
    int                cyc;
    logic              we;
    logic [ADDR_W-1:0] addr;
    logic [31:0]       data;
    logic              be;
  } strobe_t;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic [ADDR_W-1:0] mem_address;
  logic [31:0]       mem_write_data;
  logic [31:0]       mem_read_data = '0;
  logic              mem_we, mem_re, mem_be;

  load_store_unit_if #(.ADDR_W(ADDR_W)) bus ();

  load_store_unit #(.ADDR_W(ADDR_W), .MEM_BYTES(MEM_BYTES)) dut (
    .clk               (clk),
    .rst_n             (rst_n),
    .bus               (bus),
    .o_mem_address     (mem_address),
    .o_mem_write_data  (mem_write_data),
    .o_mem_write_enable(mem_we),
    .o_mem_read_enable (mem_re),
    .o_mem_byte_enable (mem_be),
    .i_mem_read_data   (mem_read_data)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int errors = 0;
  int checks = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic int bidx(input logic [ADDR_W-1:0] a, input int off);
    logic [ADDR_W-1:0] s;
    s = a + ADDR_W'(off);
    return int'(s % MEM_BYTES);
  endfunction

  // ---------------- behavioural data_memory (environment) ----------------
  logic [7:0] env_mem [MEM_BYTES];

  always @(posedge clk) begin
    if (mem_we) begin
      if (mem_be) env_mem[bidx(mem_address, 0)] <= mem_write_data[7:0];
      else for (int i = 0; i < 4; i++) env_mem[bidx(mem_address, i)] <= mem_write_data[8*i +: 8];
    end
    if (mem_re)
      mem_read_data <= mem_be ? {24'b0, env_mem[bidx(mem_address, 0)]}
                              : {env_mem[bidx(mem_address, 3)], env_mem[bidx(mem_address, 2)],
                                 env_mem[bidx(mem_address, 1)], env_mem[bidx(mem_address, 0)]};
    else
      mem_read_data <= '0;
  end

  // ---------------- reference model ----------------
  logic [7:0] mdl_mem [MEM_BYTES];
  resp_t      exp_resp[$];
  strobe_t    exp_strb[$];

  task automatic model_req(input int acc, input bit wr, input logic [1:0] sz, input bit sg,
                           input logic [ADDR_W-1:0] a, input logic [31:0] wd);
    bit          f;
    longint      last;
    logic [31:0] v;
    f = (sz == 2'd3) || (sz == 2'd1 && a[0]) || (sz == 2'd2 && a[1:0] != 2'd0);
    last = longint'(a) + ((sz == 2'd2) ? 3 : (sz == 2'd1) ? 1 : 0);
`ifdef LSU_RANGE_CHECK_EN
    if (last > MEM_BYTES - 1) f = 1'b1;
`endif
    if (f) begin
      exp_resp.push_back('{acc, 1'b1, 32'h0});
      return;
    end
    if (wr) begin
      case (sz)
        2'd0: begin
          mdl_mem[bidx(a, 0)] = wd[7:0];
          exp_strb.push_back('{acc, 1'b1, a, {24'b0, wd[7:0]}, 1'b1});
          exp_resp.push_back('{acc + 1, 1'b0, 32'h0});
        end
        2'd1: begin
          mdl_mem[bidx(a, 0)] = wd[7:0];
          mdl_mem[bidx(a, 1)] = wd[15:8];
          exp_strb.push_back('{acc, 1'b1, a, {24'b0, wd[7:0]}, 1'b1});
          exp_strb.push_back('{acc + 1, 1'b1, a + ADDR_W'(1), {24'b0, wd[15:8]}, 1'b1});
          exp_resp.push_back('{acc + 2, 1'b0, 32'h0});
        end
        default: begin
          for (int i = 0; i < 4; i++) mdl_mem[bidx(a, i)] = wd[8*i +: 8];
          exp_strb.push_back('{acc, 1'b1, a, wd, 1'b0});
          exp_resp.push_back('{acc + 1, 1'b0, 32'h0});
        end
      endcase
    end else begin
      v = {mdl_mem[bidx(a, 3)], mdl_mem[bidx(a, 2)], mdl_mem[bidx(a, 1)], mdl_mem[bidx(a, 0)]};
      if (sz == 2'd0)      v = sg ? {{24{v[7]}}, v[7:0]}   : {24'b0, v[7:0]};
      else if (sz == 2'd1) v = sg ? {{16{v[15]}}, v[15:0]} : {16'b0, v[15:0]};
      exp_strb.push_back('{acc, 1'b0, a, 32'h0, sz == 2'd0});
      exp_resp.push_back('{acc + 2, 1'b0, v});
    end
  endtask

  // ---------------- compare process ----------------
  bit          chk_en = 1'b0;
  int          last_resp_cyc = -1;
  logic        last_fault;
  logic [31:0] last_rdata;

  always @(negedge clk) begin
    bit want_r, want_s;
    if (chk_en) begin
      want_r = (exp_resp.size() > 0) && (exp_resp[0].cyc == cyc);
      if (bus.resp_valid) begin
        last_resp_cyc = cyc;
        last_fault    = bus.resp_fault;
        last_rdata    = bus.resp_rdata;
      end
      if (want_r) begin
        check("resp_valid", bus.resp_valid, 1);
        check("resp_fault", bus.resp_fault, exp_resp[0].fault);
        check("resp_rdata", bus.resp_rdata, exp_resp[0].rdata);
        check("req_ready_in_resp_cycle", bus.req_ready, 1);
        void'(exp_resp.pop_front());
      end else if (bus.resp_valid) begin
        check("unexpected_resp_valid", bus.resp_valid, 0);
      end

      want_s = (exp_strb.size() > 0) && (exp_strb[0].cyc == cyc);
      if (want_s) begin
        check("strobe_we", mem_we, exp_strb[0].we);
        check("strobe_re", mem_re, !exp_strb[0].we);
        check("strobe_addr", mem_address, exp_strb[0].addr);
        check("strobe_be", mem_be, exp_strb[0].be);
        if (exp_strb[0].we) check("strobe_wdata", mem_write_data, exp_strb[0].data);
        void'(exp_strb.pop_front());
      end else if (mem_we || mem_re) begin
        check("unexpected_strobe", {30'b0, mem_we, mem_re}, 0);
      end
    end
  end

  // ---------------- driver ----------------
  task automatic issue(input bit wr, input logic [1:0] sz, input bit sg,
                       input logic [ADDR_W-1:0] a, input logic [31:0] wd, output int acc);
    int n;
    n = 0;
    @(negedge clk);
    while (!bus.req_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!bus.req_ready) begin
      check("req_ready_timeout", bus.req_ready, 1);
      acc = -1;
      return;
    end
    bus.req_valid  = 1'b1;
    bus.req_write  = wr;
    bus.req_size   = sz;
    bus.req_signed = sg;
    bus.req_addr   = a;
    bus.req_wdata  = wd;
    acc = cyc + 1;
    model_req(acc, wr, sz, sg, a, wd);
    @(posedge clk);
    #1;
    // Fields change after acceptance; the DUT must have captured them.
    bus.req_valid  = 1'b0;
    bus.req_write  = 1'($urandom);
    bus.req_size   = 2'($urandom);
    bus.req_signed = 1'($urandom);
    bus.req_addr   = ADDR_W'($urandom);
    bus.req_wdata  = $urandom;
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while ((exp_resp.size() > 0 || exp_strb.size() > 0) && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (exp_resp.size() > 0 || exp_strb.size() > 0) begin
      check("drain_timeout", exp_resp.size() + exp_strb.size(), 0);
      exp_resp.delete();
      exp_strb.delete();
    end
  endtask

  task automatic run(input bit wr, input logic [1:0] sz, input bit sg,
                     input logic [ADDR_W-1:0] a, input logic [31:0] wd, output int acc);
    issue(wr, sz, sg, a, wd, acc);
    wait_idle();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int acc;
    logic [ADDR_W-1:0] a;
    logic [1:0] sz;

    for (int i = 0; i < MEM_BYTES; i++) begin
      env_mem[i] = 8'h00;
      mdl_mem[i] = 8'h00;
    end
    bus.req_valid = 1'b0; bus.req_write = 1'b0; bus.req_size = 2'b00;
    bus.req_signed = 1'b0; bus.req_addr = '0; bus.req_wdata = '0;

    // Reset state
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_resp_valid", bus.resp_valid, 0);
    check("rst_resp_fault", bus.resp_fault, 0);
    check("rst_resp_rdata", bus.resp_rdata, 0);
    check("rst_mem_we", mem_we, 0);
    check("rst_mem_re", mem_re, 0);
    check("rst_mem_addr", mem_address, 0);
    check("rst_req_ready", bus.req_ready, 1);
    rst_n = 1'b1;
    chk_en = 1'b1;

    // Word store then load
    run(1, 2'd2, 0, 32'h010, 32'hDEADBEEF, acc);
    check("str_fault", last_fault, 0);
    check("str_latency", last_resp_cyc - acc + 1, 2);
    run(0, 2'd2, 0, 32'h010, 32'h0, acc);
    check("ldr_deadbeef", last_rdata, 32'hDEADBEEF);
    check("ldr_latency", last_resp_cyc - acc + 1, 3);

    // Halfword store split into two byte writes
    run(1, 2'd1, 0, 32'h022, 32'h1234ABCD, acc);
    check("strh_latency", last_resp_cyc - acc + 1, 3);
    run(0, 2'd2, 0, 32'h020, 32'h0, acc);
    check("ldr_after_strh", last_rdata, 32'hABCD0000);

    // Sign extension
    run(1, 2'd0, 0, 32'h005, 32'h12345680, acc);
    check("strb_latency", last_resp_cyc - acc + 1, 2);
    run(0, 2'd0, 0, 32'h005, 32'h0, acc);
    check("ldrb_unsigned", last_rdata, 32'h00000080);
    run(0, 2'd0, 1, 32'h005, 32'h0, acc);
    check("ldrsb", last_rdata, 32'hFFFFFF80);
    run(1, 2'd1, 0, 32'h006, 32'h00008001, acc);
    run(0, 2'd1, 1, 32'h006, 32'h0, acc);
    check("ldrsh", last_rdata, 32'hFFFF8001);
    run(0, 2'd1, 0, 32'h006, 32'h0, acc);
    check("ldrh_unsigned", last_rdata, 32'h00008001);
    run(0, 2'd2, 1, 32'h004, 32'h0, acc);
    check("ldr_signed_ignored", last_rdata, 32'h80018000);

    // Faults: no strobe (compare process), memory unchanged
    run(0, 2'd2, 0, 32'h002, 32'h0, acc);
    check("fault_ldr_misaligned", last_fault, 1);
    check("fault_rdata_zero", last_rdata, 0);
    check("fault_latency", last_resp_cyc - acc + 1, 1);
    run(1, 2'd1, 0, 32'h003, 32'h0000FFFF, acc);
    check("fault_strh_odd", last_fault, 1);
    run(1, 2'd3, 0, 32'h004, 32'hFFFFFFFF, acc);
    check("fault_size_rsvd", last_fault, 1);
    run(0, 2'd2, 0, 32'h004, 32'h0, acc);
    check("mem_unchanged_after_faults", last_rdata, 32'h80018000);

    // Range check / aliasing
    run(1, 2'd2, 0, 32'h000, 32'hCAFEF00D, acc);
    run(0, 2'd2, 0, 32'h1000, 32'h0, acc);
`ifdef LSU_RANGE_CHECK_EN
    check("range_fault_0x1000", last_fault, 1);
`else
    check("alias_0x1000_fault", last_fault, 0);
    check("alias_0x1000_data", last_rdata, 32'hCAFEF00D);
`endif
    run(0, 2'd2, 0, 32'hFFC, 32'h0, acc);
    check("top_word_fault", last_fault, 0);
    check("top_word_data", last_rdata, 32'h0);

    // Reset while in LD_WAIT
    issue(0, 2'd2, 0, 32'h010, 32'h0, acc);
    @(negedge clk);
    rst_n  = 1'b0;
    chk_en = 1'b0;
    exp_resp.delete();
    exp_strb.delete();
    @(negedge clk);
    check("midrst_resp_valid", bus.resp_valid, 0);
    check("midrst_resp_rdata", bus.resp_rdata, 0);
    check("midrst_mem_re", mem_re, 0);
    check("midrst_mem_we", mem_we, 0);
    check("midrst_mem_addr", mem_address, 0);
    check("midrst_mem_be", mem_be, 0);
    check("midrst_req_ready", bus.req_ready, 1);
    rst_n = 1'b1;
    repeat (3) begin
      @(negedge clk);
      check("midrst_no_late_resp", bus.resp_valid, 0);
    end
    chk_en = 1'b1;

    // Random traffic, back-to-back where possible
    for (int n = 0; n < 400; n++) begin
      if ($urandom_range(0, 3) == 0)
        a = 32'hFC0 + 32'($urandom_range(0, 8'h7F));
      else
        a = 32'($urandom_range(0, 8'h3F));
      sz = ($urandom_range(0, 9) == 0) ? 2'd3 : 2'($urandom_range(0, 2));
      if ($urandom_range(0, 3) != 0) begin
        if (sz == 2'd1) a[0] = 1'b0;
        if (sz == 2'd2) a[1:0] = 2'b00;
      end
      issue(1'($urandom), sz, 1'($urandom), a, $urandom, acc);
      if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 3)) @(negedge clk);
    end
    wait_idle();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
